// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IOWAIT = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam int RET_W_DEF = 16;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;
  localparam int N_STG = 5;

endpackage

// File: rtl/io_handshake.sv
// IO port handshake: holds req until ack, then remembers completion until M advances.
module io_handshake (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  input  logic advance,
  output logic req,
  output logic done
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req  <= 1'b0;
      done <= 1'b0;
    end else if (req) begin
      if (ack) begin
        req  <= 1'b0;
        done <= 1'b1;
      end
    end else if (start) begin
      req <= 1'b1;
    end else if (advance) begin
      // done only needs to survive the one edge that lets the IO instruction leave M
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Turns hazard-unit requests into stage enables/flushes, tracks stage validity,
// freezes for IO transfers and HALT, and counts retired instructions.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int RET_W = RET_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             pcsrcD,
  input  logic             ioM,
  input  logic             haltW,
  input  logic             io_ack,
  output logic             enF,
  output logic             enD,
  output logic             enE,
  output logic             enM,
  output logic             enW,
  output logic             flushD,
  output logic             flushE,
  output logic             validD,
  output logic             validE,
  output logic             validM,
  output logic             validW,
  output logic             io_req,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  function automatic logic [RET_W-1:0] sat_inc(input logic [RET_W-1:0] v);
    return (v == {RET_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t           state;
  logic             io_done;
  logic             io_start;
  logic             freeze;
  logic             advance;
  logic [N_STG-1:0] en;

  assign io_start = (state == RUN) && validM && ioM && !io_done;
  assign freeze   = (state != RUN) || io_start;
  assign advance  = !freeze;

  always_comb begin
    en     = '1;
    flushD = 1'b0;
    flushE = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        en = '0;
      end else begin
        en[STG_F] = !stallF;
        en[STG_D] = !stallD;
        flushD    = pcsrcD;
        flushE    = stallD;
      end
    end
  end

  assign enF = en[STG_F];
  assign enD = en[STG_D];
  assign enE = en[STG_E];
  assign enM = en[STG_M];
  assign enW = en[STG_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (io_start) begin
            state <= IOWAIT;
          end else if (validW && haltW) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        IOWAIT: begin
          if (io_ack) state <= RUN;
        end
        HALT:    halted <= 1'b1;
        default: state  <= RUN;
      endcase
    end
  end

  // Stage valid tracking: bits move only on unfrozen edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      validD <= 1'b0;
      validE <= 1'b0;
      validM <= 1'b0;
      validW <= 1'b0;
    end else if (advance) begin
      validD <= flushD ? 1'b0 : (en[STG_D] ? 1'b1 : validD);
      validE <= stallD ? 1'b0 : validD;
      validM <= validE;
      validW <= validM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (advance && validW) begin
      retired <= sat_inc(retired);
    end
  end

  io_handshake u_io (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (io_start),
    .ack     (io_ack),
    .advance (advance),
    .req     (io_req),
    .done    (io_done)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized run against a behavioural model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n, stallF, stallD, pcsrcD, ioM, haltW, io_ack;

  logic enF, enD, enE, enM, enW, flushD, flushE;
  logic validD, validE, validM, validW, io_req, halted;
  logic [15:0] retired;

  logic enF_s, enD_s, enE_s, enM_s, enW_s, flushD_s, flushE_s;
  logic validD_s, validE_s, validM_s, validW_s, io_req_s, halted_s;
  logic [1:0] retired_s;

  logic [4:0] en, en_s;
  logic [1:0] flush, flush_s;
  logic [3:0] valid, valid_s;

  assign en      = {enF, enD, enE, enM, enW};
  assign en_s    = {enF_s, enD_s, enE_s, enM_s, enW_s};
  assign flush   = {flushD, flushE};
  assign flush_s = {flushD_s, flushE_s};
  assign valid   = {validD, validE, validM, validW};
  assign valid_s = {validD_s, validE_s, validM_s, validW_s};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.RET_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .pcsrcD(pcsrcD),
    .ioM(ioM), .haltW(haltW), .io_ack(io_ack),
    .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
    .flushD(flushD), .flushE(flushE),
    .validD(validD), .validE(validE), .validM(validM), .validW(validW),
    .io_req(io_req), .halted(halted), .retired(retired)
  );

  // Narrow counter copy, driven identically, to exercise saturation quickly
  pipeline_ctrl #(.RET_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .pcsrcD(pcsrcD),
    .ioM(ioM), .haltW(haltW), .io_ack(io_ack),
    .enF(enF_s), .enD(enD_s), .enE(enE_s), .enM(enM_s), .enW(enW_s),
    .flushD(flushD_s), .flushE(flushE_s),
    .validD(validD_s), .validE(validE_s), .validM(validM_s), .validW(validW_s),
    .io_req(io_req_s), .halted(halted_s), .retired(retired_s)
  );

  // Behavioural model: mode 0=running, 1=waiting on IO port, 2=halted
  int m_mode;
  bit m_v[4];
  bit m_done, m_req;
  int m_ret;

  task automatic model_reset();
    m_mode = 0;
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    m_done = 1'b0;
    m_req  = 1'b0;
    m_ret  = 0;
  endtask

  function automatic bit model_frozen();
    return (m_mode != 0) || (m_v[2] && ioM && !m_done);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (model_frozen()) begin
        m_mode = 1;
        m_req  = 1'b1;
      end else begin
        if (m_v[3] && m_ret < 65535) m_ret = m_ret + 1;
        if (m_v[3] && haltW) m_mode = 2;
        m_v[3] = m_v[2];
        m_v[2] = m_v[1];
        m_v[1] = stallD ? 1'b0 : m_v[0];
        if (pcsrcD) m_v[0] = 1'b0;
        else if (!stallD) m_v[0] = 1'b1;
        m_done = 1'b0;
      end
    end else if (m_mode == 1) begin
      if (io_ack) begin
        m_mode = 0;
        m_req  = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic clear_inputs();
    stallF = 0; stallD = 0; pcsrcD = 0; ioM = 0; haltW = 0; io_ack = 0;
  endtask

  task automatic rand_inputs();
    stallD = ($urandom_range(0, 5) == 0);
    stallF = stallD | ($urandom_range(0, 9) == 0);
    pcsrcD = ($urandom_range(0, 5) == 0);
    ioM    = ($urandom_range(0, 3) == 0);
    haltW  = ($urandom_range(0, 39) == 0);
    io_ack = ($urandom_range(0, 2) == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 0;
    clear_inputs();
    tick();
    rst_n = 1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    stallF = 1; stallD = 1; pcsrcD = 1; ioM = 0; haltW = 0; io_ack = 0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL reset_en got %b want 11111", en); end
    checks++; if (flush !== 2'b00) begin errors++; $display("FAIL reset_flush got %b want 00", flush); end
    checks++; if (valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", valid); end
    checks++; if ({io_req, halted} !== 2'b00) begin errors++; $display("FAIL reset_req_halt got %b want 00", {io_req, halted}); end
    checks++; if (retired !== 16'd0 || retired_s !== 2'd0) begin
      errors++; $display("FAIL reset_retired got %0d/%0d want 0/0", retired, retired_s);
    end
    tick();
    rst_n = 1;
    clear_inputs();
    for (int i = 1; i <= 6; i++) begin
      logic [3:0] xv;
      int xr;
      tick();
      @(negedge clk);
      xv = {i >= 1, i >= 2, i >= 3, i >= 4};
      xr = (i >= 5) ? i - 4 : 0;
      checks++; if (valid !== xv) begin errors++; $display("FAIL fill_valid[%0d] got %b want %b", i, valid, xv); end
      checks++; if (retired !== 16'(xr)) begin errors++; $display("FAIL fill_retired[%0d] got %0d want %0d", i, retired, xr); end
      checks++; if (en !== 5'b11111) begin errors++; $display("FAIL fill_en[%0d] got %b want 11111", i, en); end
    end
  endtask

  task automatic test_stall();
    int xr[4] = '{2, 3, 3, 4};
    bit xw[4] = '{1, 0, 1, 1};
    restart();
    stallF = 1; stallD = 1;
    @(negedge clk);
    checks++; if (en !== 5'b00111) begin errors++; $display("FAIL stall_en got %b want 00111", en); end
    checks++; if (flush !== 2'b01) begin errors++; $display("FAIL stall_flush got %b want 01", flush); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (valid !== 4'b1011) begin errors++; $display("FAIL stall_valid got %b want 1011", valid); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL stall_retired got %0d want 1", retired); end
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      checks++; if (validW !== xw[k] || retired !== 16'(xr[k])) begin
        errors++; $display("FAIL stall_slot[%0d] got vW=%b ret=%0d want vW=%b ret=%0d", k, validW, retired, xw[k], xr[k]);
      end
    end
  endtask

  task automatic test_branch();
    restart();
    pcsrcD = 1;
    @(negedge clk);
    checks++; if (flush !== 2'b10 || en !== 5'b11111) begin
      errors++; $display("FAIL branch_ctl got flush=%b en=%b want 10/11111", flush, en);
    end
    tick();
    pcsrcD = 0;
    @(negedge clk);
    checks++; if (valid !== 4'b0111) begin errors++; $display("FAIL branch_v1 got %b want 0111", valid); end
    tick();
    @(negedge clk);
    checks++; if (valid !== 4'b1011) begin errors++; $display("FAIL branch_v2 got %b want 1011", valid); end
    tick();
    @(negedge clk);
    checks++; if (valid !== 4'b1101) begin errors++; $display("FAIL branch_v3 got %b want 1101", valid); end
  endtask

  task automatic test_stall_and_branch();
    restart();
    stallF = 1; stallD = 1; pcsrcD = 1;
    @(negedge clk);
    checks++; if (en !== 5'b00111 || flush !== 2'b11) begin
      errors++; $display("FAIL both_ctl got en=%b flush=%b want 00111/11", en, flush);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (valid !== 4'b0011) begin errors++; $display("FAIL both_valid got %b want 0011", valid); end
  endtask

  task automatic test_io();
    restart();
    ioM = 1;
    @(negedge clk);
    checks++; if (en !== 5'b00000 || io_req !== 1'b0) begin
      errors++; $display("FAIL io_enter got en=%b req=%b want 00000/0", en, io_req);
    end
    tick();
    stallD = 1; pcsrcD = 1; stallF = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (io_req !== 1'b1 || en !== 5'b00000 || flush !== 2'b00) begin
        errors++; $display("FAIL io_wait[%0d] got req=%b en=%b flush=%b want 1/00000/00", k, io_req, en, flush);
      end
      checks++; if (valid !== 4'b1111 || retired !== 16'd0) begin
        errors++; $display("FAIL io_hold[%0d] got valid=%b ret=%0d want 1111/0", k, valid, retired);
      end
      tick();
    end
    stallD = 0; pcsrcD = 0; stallF = 0;
    io_ack = 1;
    @(negedge clk);
    checks++; if (io_req !== 1'b1 || en !== 5'b00000) begin
      errors++; $display("FAIL io_ackcyc got req=%b en=%b want 1/00000", io_req, en);
    end
    tick();
    io_ack = 0;
    @(negedge clk);
    checks++; if (io_req !== 1'b0 || en !== 5'b11111 || retired !== 16'd0) begin
      errors++; $display("FAIL io_release got req=%b en=%b ret=%0d want 0/11111/0", io_req, en, retired);
    end
    tick();
    ioM = 0;
    @(negedge clk);
    checks++; if (retired !== 16'd1 || valid !== 4'b1111) begin
      errors++; $display("FAIL io_adv got ret=%0d valid=%b want 1/1111", retired, valid);
    end
    tick();
    io_ack = 1;
    @(negedge clk);
    checks++; if (retired !== 16'd2 || io_req !== 1'b0 || en !== 5'b11111) begin
      errors++; $display("FAIL io_retire got ret=%0d req=%b en=%b want 2/0/11111", retired, io_req, en);
    end
    tick();
    io_ack = 0;
    @(negedge clk);
    checks++; if (io_req !== 1'b0 || retired !== 16'd3 || en !== 5'b11111) begin
      errors++; $display("FAIL io_stray_ack got req=%b ret=%0d en=%b want 0/3/11111", io_req, retired, en);
    end
  endtask

  task automatic test_halt();
    restart();
    haltW = 1;
    @(negedge clk);
    checks++; if (en !== 5'b11111 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_pre got en=%b halted=%b want 11111/0", en, halted);
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      rand_inputs();
      @(negedge clk);
      checks++; if (halted !== 1'b1 || en !== 5'b00000 || flush !== 2'b00 || io_req !== 1'b0) begin
        errors++; $display("FAIL halt_hold[%0d] got halted=%b en=%b flush=%b req=%b want 1/00000/00/0", k, halted, en, flush, io_req);
      end
      checks++; if (retired !== 16'd1 || retired_s !== 2'd1) begin
        errors++; $display("FAIL halt_ret[%0d] got %0d/%0d want 1/1", k, retired, retired_s);
      end
      tick();
    end
    rst_n = 0;
    clear_inputs();
    tick();
    @(negedge clk);
    checks++; if (halted !== 1'b0 || retired !== 16'd0 || valid !== 4'b0000) begin
      errors++; $display("FAIL halt_reset got halted=%b ret=%0d valid=%b want 0/0/0000", halted, retired, valid);
    end
    rst_n = 1;
  endtask

  task automatic test_saturate();
    restart();
    for (int k = 1; k <= 5; k++) begin
      int xs;
      tick();
      @(negedge clk);
      xs = (k > 3) ? 3 : k;
      checks++; if (retired_s !== 2'(xs) || retired !== 16'(k)) begin
        errors++; $display("FAIL sat[%0d] got %0d/%0d want %0d/%0d", k, retired_s, retired, xs, k);
      end
    end
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    rst_n = 0;
    clear_inputs();
    tick();
    model_reset();
    for (int i = 0; i < 800; i++) begin
      logic [4:0] xe;
      logic [1:0] xf;
      logic [3:0] xv;
      logic [1:0] xs;
      bit frz;
      rand_inputs();
      halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
      rst_n = !(($urandom_range(0, 99) == 0) || halt_cycles > 12);
      @(negedge clk);
      frz = model_frozen();
      if (!rst_n) begin xe = 5'b11111; xf = 2'b00; end
      else if (frz) begin xe = 5'b00000; xf = 2'b00; end
      else begin xe = {!stallF, !stallD, 3'b111}; xf = {pcsrcD, stallD}; end
      xv = {m_v[0], m_v[1], m_v[2], m_v[3]};
      xs = (m_ret > 3) ? 2'd3 : 2'(m_ret);
      checks++; if (en !== xe || en_s !== xe) begin
        errors++; $display("FAIL rnd_en[%0d] got %b/%b want %b", i, en, en_s, xe);
      end
      checks++; if (flush !== xf || flush_s !== xf) begin
        errors++; $display("FAIL rnd_flush[%0d] got %b/%b want %b", i, flush, flush_s, xf);
      end
      checks++; if (valid !== xv || valid_s !== xv) begin
        errors++; $display("FAIL rnd_valid[%0d] got %b/%b want %b", i, valid, valid_s, xv);
      end
      checks++; if (io_req !== m_req || io_req_s !== m_req) begin
        errors++; $display("FAIL rnd_req[%0d] got %b/%b want %b", i, io_req, io_req_s, m_req);
      end
      checks++; if (halted !== (m_mode == 2) || halted_s !== (m_mode == 2)) begin
        errors++; $display("FAIL rnd_halted[%0d] got %b/%b want %b", i, halted, halted_s, m_mode == 2);
      end
      checks++; if (retired !== 16'(m_ret) || retired_s !== xs) begin
        errors++; $display("FAIL rnd_retired[%0d] got %0d/%0d want %0d/%0d", i, retired, retired_s, m_ret, xs);
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_stall();
    test_branch();
    test_stall_and_branch();
    test_io();
    test_halt();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumes the hazard unit's stall/branch requests and turns them into per-stage register enables, flushes and valid tracking for the 5-stage F/D/E/M/W pipeline.
- Owns the multi-cycle freeze for IO instructions (req/ack handshake to the IO port), the sticky HALT state and a retired-instruction counter.
- Sits between the hazard unit and the pipeline registers / PC register.

Parameters:
- RET_W, 16, width of the retired-instruction counter (saturating).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low (sampled on rising clk)
- stallF  in  1  hazard: hold PC
- stallD  in  1  hazard: hold IF/ID, bubble into E
- pcsrcD  in  1  branch taken in D
- ioM  in  1  instruction in M is IO (in/out)
- haltW  in  1  instruction in W is halt
- io_ack  in  1  IO port completed the transfer (single-cycle pulse)
- enF  out  1  PC enable
- enD  out  1  IF/ID enable
- enE, enM, enW  out  1 each  ID/EX, EX/MEM, MEM/WB enables
- flushD  out  1  clear IF/ID
- flushE  out  1  clear ID/EX (bubble)
- validD, validE, validM, validW  out  1 each  stage holds a real instruction
- io_req  out  1  IO transfer request, held until ack
- halted  out  1  processor halted
- retired  out  RET_W  retired-instruction count

Behaviour:
- State machine states: RUN, IOWAIT, HALT. Reset: state=RUN; all valid*=0; io_done=0; retired=0; io_req=0; halted=0.
- Reset outputs: enF/enD/enE/enM/enW=1, flushD=0, flushE=0.
- freeze (combinational) = (state==IOWAIT) | (state==HALT) | (state==RUN & validM & ioM & ~io_done).
- RUN, freeze=0:
  - enF = ~stallF; enD = ~stallD; enE = enM = enW = 1.
  - flushD = pcsrcD (kills the wrong-path fetch); flushE = stallD.
- Any freeze=1: all en*=0, flushD=flushE=0. Registers and valid bits hold.
- Valid update when freeze=0:
  - validD <= flushD ? 0 : (enD ? 1 : validD). After reset, validD becomes 1 at the first unfrozen edge.
  - validE <= stallD ? 0 : validD.
  - validM <= validE.
  - validW <= validM.
- Transitions:
  - RUN -> IOWAIT when validM & ioM & ~io_done.
  - IOWAIT: io_req=1 (registered, first high the cycle after entry). On io_ack, set io_done=1 and go to RUN; io_req drops the same edge. The next cycle freeze=0 and M advances.
  - io_done clears on the first unfrozen edge after it is set.
  - RUN -> HALT when validW & haltW & ~freeze. HALT is sticky until rst_n: halted=1, all en*=0, no retire.
  - io_ack outside IOWAIT is ignored.
- Retire: retired increments on an unfrozen RUN edge with validW=1, including the halt instruction itself. It saturates at 2^RET_W-1 and does not wrap.
- Priorities: reset > HALT > IO freeze > hazard stall/flush.
- Simultaneous stallD & pcsrcD: enD=0, flushD=1 (flush wins on IF/ID), flushE=1.
- Reset mid-IOWAIT: io_req drops on the reset edge; state returns to RUN with all valid=0.

Decomposition:
- Shared package pipe_pkg holds: state encoding (RUN=2'd0, IOWAIT=2'd1, HALT=2'd2); RET_W default; stage index constants.
- Optional sub-module: io_handshake (owns IOWAIT, io_req, io_done).

Test Plan:
- Reset release, no hazards, 6 cycles: validD..W fill one per cycle; retired=2 after cycle 6; en*=1.
- stallF=stallD=1 for 1 cycle with validD=1: enF=enD=0, flushE=1, validE=0 next cycle; retired count skips one slot.
- pcsrcD=1 for 1 cycle: flushD=1, validD=0 next cycle; E receives a bubble.
- ioM=1 with validM: io_req rises the next cycle; hold io_ack=0 for 4 cycles, all en*=0 throughout; after io_ack pulse io_req=0 next cycle, pipeline advances, retired +1 when the IO instruction reaches W.
- haltW with validW: retired increments once; halted=1 next cycle and stays through 10 cycles of arbitrary stall/io_ack stimulus; rst_n=0 clears it.
- Preload retired to 0xFFFE, retire 3 instructions: reads 0xFFFF and holds there.
